// File: rtl/uart_tx_frame_pkg.sv
// uart_tx_frame_pkg: state encoding, line levels and parity helpers shared by the UART TX/RX paths
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  // Parity bit from the XOR-reduction of the payload and the parity type
  function automatic logic calc_parity(input logic xor_v, input logic typ);
    return (typ == PAR_EVEN) ? xor_v : ~xor_v;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register and bit counter for the TX framer
module uart_tx_serializer
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_i,
  output logic                  next_bit_o,
  output logic                  last_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(DATA_WIDTH - 1));
  // Bit that goes on the line next: bit 0 when entering DATA, the following bit while shifting
  assign next_bit_o = shift_i ? sh_q[1] : sh_q[0];

  // Load on acceptance, shift right once per DATA cycle, counter wraps to 0 after the last bit
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = sh_q >> 1;
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Shift register and counter state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer (start, LSB-first data, optional parity, stop) at one bit per clock
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_q, par_d;
  logic      par_en_q, par_en_d;
  logic      accept;
  logic      ser_bit;
  logic      ser_last;

  assign accept = Data_Valid && (state_q == ST_IDLE || state_q == ST_STOP);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (accept),
    .data_i    (P_DATA),
    .shift_i   (state_q == ST_DATA),
    .next_bit_o(ser_bit),
    .last_o    (ser_last)
  );

  // Next state, per-frame config capture, and the registered line level derived from the next state
  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    case (state_q)
      ST_IDLE:   state_d = accept ? ST_START : ST_IDLE;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   state_d = !ser_last ? ST_DATA : (par_en_q ? ST_PARITY : ST_STOP);
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (accept) begin
      par_d    = calc_parity(^P_DATA, PAR_TYP);
      par_en_d = PAR_EN;
    end
    tx_d   = (state_d == ST_START)  ? START_BIT :
             (state_d == ST_DATA)   ? ser_bit :
             (state_d == ST_PARITY) ? par_q :
             (state_d == ST_STOP)   ? STOP_BIT : IDLE_LEVEL;
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, parity latch and glitch-free output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed self-checking bench for the UART TX framer
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int n_chk;
  int n_fail;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present a word for one edge, then scramble the inputs to show they are not re-sampled
  task automatic send(input logic [7:0] d, input logic en, input logic typ);
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = en;
    PAR_TYP = typ;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    P_DATA = ~d;
    PAR_EN = ~en;
    PAR_TYP = ~typ;
  endtask

  // Check the line cycle by cycle against a string in transmit order; optionally poke Data_Valid mid-frame
  task automatic check_seq(input string tag, input string s, input int poke);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge CLK);
      chk($sformatf("%s_tx[%0d]", tag, i), TX_OUT, s[i] == "1");
      chk($sformatf("%s_busy[%0d]", tag, i), busy, 1'b1);
      if (i == poke) begin
        P_DATA = 8'hFF;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk($sformatf("%s_tx[%0d]", tag, i), TX_OUT, 1'b1);
      chk($sformatf("%s_busy[%0d]", tag, i), busy, 1'b0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    RST = 1'b0;
    P_DATA = 8'hA5;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    @(negedge CLK);
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", busy, 1'b0);
    @(negedge CLK);
    chk("reset_hold_tx", TX_OUT, 1'b1);
    chk("reset_hold_busy", busy, 1'b0);
    Data_Valid = 1'b0;
    RST = 1'b1;
    check_idle("post_reset", 2);
    // 0xA5, no parity
    send(8'hA5, 1'b0, 1'b0);
    check_seq("a5_nopar", "0101001011", -1);
    check_idle("a5_nopar_end", 2);
    // 0xA5, even parity (four ones -> 0)
    send(8'hA5, 1'b1, 1'b0);
    check_seq("a5_even", "01010010101", -1);
    check_idle("a5_even_end", 1);
    // 0xA5, odd parity -> 1
    send(8'hA5, 1'b1, 1'b1);
    check_seq("a5_odd", "01010010111", -1);
    check_idle("a5_odd_end", 1);
    // 0x00, odd parity -> 1
    send(8'h00, 1'b1, 1'b1);
    check_seq("z_odd", "00000000011", -1);
    check_idle("z_odd_end", 1);
    // Back-to-back with Data_Valid held high: 0x3C then 0xC3
    @(negedge CLK);
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'hC3;
    check_seq("b2b_1", "0001111001", -1);
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    check_seq("b2b_2", "0110000111", -1);
    check_idle("b2b_end", 2);
    // Mid-frame: P_DATA to 0xFF and a Data_Valid pulse during DATA
    send(8'h5A, 1'b0, 1'b0);
    check_seq("mid", "0010110101", 3);
    check_idle("mid_end", 3);
    // Reset during data bit 4
    send(8'hA5, 1'b0, 1'b0);
    check_seq("rst_pre", "010100", -1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_mid_tx", TX_OUT, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("rst_post", 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit-side UART framer: accepts a parallel byte with a one-cycle valid strobe, then serialises it LSB-first as start bit, data bits, optional parity and stop bit on a single line. It pairs with the receive path (start/parity/stop checkers and deserialiser) and runs on the TX clock domain at one bit per clock, so a baud-rate divider or prescaler upstream sets the rate. Configuration comes from the register file and is captured per frame.

## Interface
- DATA_WIDTH, 8, number of payload bits per frame
- CLK  input  1  TX bit clock; all state updates on rising edge
- RST  input  1  asynchronous active-low reset
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance
- Data_Valid  input  1  payload strobe; accepted only when idle or in the stop cycle
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance
- TX_OUT  output  1  serial line, idles high
- busy  output  1  high while a frame is on the line

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: rising edge with Data_Valid=1 and state IDLE or STOP. On acceptance, latch P_DATA, PAR_EN and PAR_TYP, compute parity, and go to START.
- Data_Valid in START, DATA or PARITY is ignored and has no side effect. Input changes after acceptance do not affect the current frame.
- START lasts 1 cycle with TX_OUT=0, then goes to DATA.
- DATA lasts DATA_WIDTH cycles with TX_OUT = latched bit[i] for i=0..DATA_WIDTH-1, LSB first. A bit counter of width clog2(DATA_WIDTH) wraps to 0 on exit.
- After DATA, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY lasts 1 cycle with TX_OUT = XOR of the latched data when even, or its inverse when odd.
- STOP lasts 1 cycle with TX_OUT=1. Then go to IDLE, or to START if a new word is accepted in that cycle, giving back-to-back frames with no idle gap.
- IDLE: TX_OUT=1, busy=0.
- TX_OUT and busy are registered outputs and are glitch-free.

## Timing
- Reset (RST=0, any state, asynchronous): state=IDLE, TX_OUT=1, busy=0, counter=0, latched data=0. Reset mid-frame aborts the frame immediately and the line returns high.
- Latency: acceptance at edge N gives TX_OUT=0 and busy=1 from edge N.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity. That is 10 or 11 cycles for DATA_WIDTH=8.
- busy stays 1 from the START edge through the end of the STOP cycle. It falls at the edge that leaves STOP only if no new word is accepted; back-to-back frames keep busy=1 continuously.
- Data_Valid held high continuously produces frames back-to-back, each sampling P_DATA at its own STOP→START edge.
- Data_Valid asserted in the same cycle reset is released is not accepted; the first accepting edge is the first edge with RST=1.

## Structure
- Shared UART package:
  - state encoding (3-bit enum)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - PAR_EVEN=1'b0, PAR_ODD=1'b1
  - these constants are shared with the RX checkers
- One sub-module: uart_tx_serializer. It holds the shift register and bit counter, loads on acceptance, shifts on DATA cycles and flags the last bit.
- The top level holds the FSM, the parity register and the output mux, registered.

## Test plan
- 0xA5, PAR_EN=0: TX_OUT from the START edge is 0,1,0,1,0,0,1,0,1,1 (10 cycles). busy=1 for exactly 10 cycles, then TX_OUT=1 and busy=0.
- 0xA5, PAR_EN=1, PAR_TYP=0 → parity bit 0; the same with PAR_TYP=1 → parity bit 1. Frame is 11 cycles.
- 0x00 with odd parity → data bits all 0, parity 1, stop 1.
- Back-to-back: Data_Valid held high with 0x3C then 0xC3. The second start bit appears the cycle after the first stop bit, and busy never drops.
- Mid-frame: change P_DATA to 0xFF and pulse Data_Valid during DATA → the frame is unchanged and no extra frame is sent.
- Assert RST=0 during data bit 4 → TX_OUT=1 and busy=0 immediately. After release, the line stays idle until the next Data_Valid.
